dds_multichannel_core: RTL

Parametrised multi-channel direct digital synthesis core. It is the successor to the single-channel, fixed-mode waveform top. Each of `CHANNELS` independent channels has a phase accumulator with a programmable tuning word and phase offset, and produces sine, triangle, square or PWM. All channels share one clock and a common configuration port. Configuration is double-buffered and applied atomically to all channels on a commit, so the outputs feed the DAC/output mux as a phase-coherent sample bus.

---
 rtl/dds_multichannel_core_if.sv | 26 ++
 rtl/dds_multichannel_core.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dds_multichannel_core_if.sv
// Configuration port and sample bus of dds_multichannel_core.
// master = host/testbench side, slave = core side.
interface dds_multichannel_core_if #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned OUT_W    = 16
);
    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [2:0]                cfg_ch;
    logic [2:0]                cfg_addr;
    logic [31:0]               cfg_data;
    logic                      commit;
    logic                      commit_phase_clr;
    logic                      out_valid;
    logic [CHANNELS*OUT_W-1:0] out_data;

    modport master (
        output cfg_valid, cfg_ch, cfg_addr, cfg_data, commit, commit_phase_clr,
        input  cfg_ready, out_valid, out_data
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_addr, cfg_data, commit, commit_phase_clr,
        output cfg_ready, out_valid, out_data
    );
endinterface

// File: rtl/dds_multichannel_core.sv
// Multi-channel DDS: double-buffered per-channel config, phase accumulators, 3-stage waveform pipe.
// Define DDS_AMPLITUDE_EN to add the per-channel amplitude register (addr 4) and output scaler.
module dds_multichannel_core #(
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned ACC_W      = 32,
    parameter int unsigned LUT_ADDR_W = 8,
    parameter int unsigned OUT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    dds_multichannel_core_if.slave bus
);
    localparam int unsigned      PH_W        = LUT_ADDR_W + 2;
    localparam int unsigned      QUARTER     = 1 << LUT_ADDR_W;
    localparam logic [OUT_W-1:0] FS          = '1;
    localparam logic [OUT_W-1:0] MID         = {1'b1, {(OUT_W-1){1'b0}}};
    localparam longint           PI_HALF_Q30 = 64'sd1686629713;

    // Quarter-wave magnitude sin(pi/2 * idx / QUARTER), Taylor series in Q30 fixed point.
    function automatic logic [OUT_W-2:0] sine_q(input int unsigned idx);
        longint x, x2, term, sum;
        x    = (PI_HALF_Q30 * longint'(idx)) >>> LUT_ADDR_W;
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int k = 1; k <= 6; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        if (sum < 0) sum = 0;
        return (OUT_W-1)'((sum * ((longint'(1) << (OUT_W - 1)) - 1) + (longint'(1) << 29)) >>> 30);
    endfunction

    // Stretch the folded phase to OUT_W by bit replication so the peak reaches FS exactly.
    function automatic logic [OUT_W-1:0] tri_scale(input logic [PH_W-2:0] t);
        logic [OUT_W-1:0] r;
        r = '0;
        for (int j = 0; j < OUT_W; j++) r[OUT_W-1-j] = t[PH_W-2-(j % (PH_W-1))];
        return r;
    endfunction

    logic [OUT_W-2:0] rom [QUARTER];
    for (genvar i = 0; i < QUARTER; i++) begin : g_rom
        assign rom[i] = sine_q(i);
    end

    logic ready_q, cfg_fire, commit_clr;
    logic v1_q, v2_q, out_valid_q;
    logic unused_data;

    // Writes are held off during a commit so they never race the shadow->active copy.
    assign bus.cfg_ready = ready_q & ~bus.commit;
    assign cfg_fire      = bus.cfg_valid & bus.cfg_ready;
    assign commit_clr    = bus.commit & bus.commit_phase_clr;
    assign bus.out_valid = out_valid_q;
    assign unused_data   = ^bus.cfg_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q     <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            ready_q     <= 1'b1;
            v1_q        <= run;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
        end
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic                  sel;
        logic [ACC_W-1:0]      ftw_sh_q, ftw_q, acc_q;
        logic [PH_W-1:0]       ofs_sh_q, ofs_q, ph, s1_ph_q;
        logic [1:0]            mode_sh_q, mode_q, s1_mode_q;
        logic [7:0]            duty_sh_q, duty_q, s1_duty_q;
        logic [LUT_ADDR_W-1:0] s1_addr_q;
        logic [OUT_W-2:0]      rom_mag;
        logic [OUT_W-1:0]      sine_wave, tri_wave, wave, s2_wave_q, scaled, out_q;

        assign sel       = cfg_fire && (bus.cfg_ch == 3'(n));
        assign ph        = acc_q[ACC_W-1 -: PH_W] + ofs_q;
        assign rom_mag   = rom[s1_addr_q];
        assign sine_wave = s1_ph_q[PH_W-1] ? (MID - {1'b0, rom_mag}) : (MID + {1'b0, rom_mag});
        assign tri_wave  = tri_scale(s1_ph_q[PH_W-1] ? ~s1_ph_q[PH_W-2:0] : s1_ph_q[PH_W-2:0]);
        assign bus.out_data[n*OUT_W +: OUT_W] = out_q;

`ifdef DDS_AMPLITUDE_EN
        localparam int unsigned PW = OUT_W + 10;
        localparam int unsigned QW = OUT_W + 8;
        logic [7:0]            amp_sh_q, amp_q, s1_amp_q, s2_amp_q;
        logic                  s2_pulse_q;
        logic signed [PW-1:0]  diff_x, amp_x, prod;
        logic [QW-1:0]         pulse_prod;

        always_comb begin
            diff_x     = PW'(signed'({1'b0, s2_wave_q}) - signed'({1'b0, MID}));
            amp_x      = PW'({1'b0, s2_amp_q});
            prod       = diff_x * amp_x;
            pulse_prod = QW'(s2_wave_q) * QW'(s2_amp_q);
            scaled     = s2_pulse_q ? pulse_prod[QW-1:8] : (MID + OUT_W'(prod >>> 8));
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                amp_sh_q   <= 8'hFF;
                amp_q      <= 8'hFF;
                s1_amp_q   <= 8'hFF;
                s2_amp_q   <= 8'hFF;
                s2_pulse_q <= 1'b0;
            end else begin
                if (sel && bus.cfg_addr == 3'd4) amp_sh_q <= bus.cfg_data[7:0];
                if (bus.commit) amp_q <= amp_sh_q;
                s1_amp_q   <= amp_q;
                s2_amp_q   <= s1_amp_q;
                s2_pulse_q <= s1_mode_q[1];
            end
        end
`else
        assign scaled = s2_wave_q;
`endif

        always_comb begin
            wave = sine_wave;
            case (s1_mode_q)
                2'd0:    wave = sine_wave;
                2'd1:    wave = tri_wave;
                2'd2:    wave = s1_ph_q[PH_W-1] ? '0 : FS;
                2'd3:    wave = (s1_ph_q[PH_W-1 -: 8] < s1_duty_q) ? FS : '0;
                default: wave = sine_wave;
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                ftw_sh_q  <= '0;
                ofs_sh_q  <= '0;
                mode_sh_q <= '0;
                duty_sh_q <= '0;
                ftw_q     <= '0;
                ofs_q     <= '0;
                mode_q    <= '0;
                duty_q    <= '0;
            end else begin
                if (sel) begin
                    case (bus.cfg_addr)
                        3'd0:    ftw_sh_q  <= ACC_W'(bus.cfg_data);
                        3'd1:    ofs_sh_q  <= PH_W'(bus.cfg_data);
                        3'd2:    mode_sh_q <= bus.cfg_data[1:0];
                        3'd3:    duty_sh_q <= bus.cfg_data[7:0];
                        default: ;
                    endcase
                end
                if (bus.commit) begin
                    ftw_q  <= ftw_sh_q;
                    ofs_q  <= ofs_sh_q;
                    mode_q <= mode_sh_q;
                    duty_q <= duty_sh_q;
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                acc_q     <= '0;
                s1_ph_q   <= '0;
                s1_addr_q <= '0;
                s1_mode_q <= '0;
                s1_duty_q <= '0;
                s2_wave_q <= '0;
                out_q     <= '0;
            end else begin
                if (commit_clr) acc_q <= '0;
                else if (run)   acc_q <= acc_q + ftw_q;
                s1_ph_q   <= ph;
                s1_addr_q <= ph[PH_W-2] ? ~ph[LUT_ADDR_W-1:0] : ph[LUT_ADDR_W-1:0];
                s1_mode_q <= mode_q;
                s1_duty_q <= duty_q;
                s2_wave_q <= wave;
                if (v2_q) out_q <= scaled;
            end
        end
    end
endmodule
